// File: rtl/iq_issue_scheduler.sv
// rtl/iq_issue_scheduler.sv - oldest-ready issue scheduler for the mips_core instruction queue
// Optional IQ_MEM_ORDER_EN: memory ops become eligible only when no older memory op is queued.
package mips_core_pkg;
  typedef logic [5:0] MipsReg;
  typedef struct packed {
    logic [31:0] pc;
    logic [5:0]  op;
    MipsReg      rs_addr;
    MipsReg      rt_addr;
    MipsReg      rw_addr;
    logic        uses_rs;
    logic        uses_rt;
    logic        uses_rw;
    logic        is_mem_access;
    logic [31:0] count;
  } Instr_Queue_Entry_t;
endpackage

module iq_issue_scheduler
  import mips_core_pkg::*;
#(
  parameter int          DEPTH    = 8,
  parameter int          IDX_W    = $clog2(DEPTH),
  // Reset value of the dispatch sequence counter; nonzero only to exercise wrap.
  parameter logic [31:0] SEQ_INIT = 32'd0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               disp_valid,
  output logic               disp_ready,
  input  Instr_Queue_Entry_t disp_entry,
  input  logic               disp_rs_rdy,
  input  logic               disp_rt_rdy,
  input  logic               wb_valid,
  input  logic [5:0]         wb_tag,
  output logic               issue_valid,
  input  logic               issue_ready,
  output Instr_Queue_Entry_t issue_entry,
  output logic [IDX_W-1:0]   issue_idx,
  output logic [IDX_W:0]     occupancy
);

  logic [DEPTH-1:0]   valid_q, rs_rdy_q, rt_rdy_q;
  Instr_Queue_Entry_t entry_q [DEPTH];
  logic [31:0]        seq_q;
  logic [IDX_W:0]     occ_q;

  logic [DEPTH-1:0]   elig;
  logic               found;
  logic [IDX_W-1:0]   sel_idx, free_idx;
  logic [31:0]        best_cnt;
  logic               disp_fire, issue_fire, disp_rs_d, disp_rt_d;
  Instr_Queue_Entry_t disp_wr;

  // Wrap-safe age compare: a is older than b when (a - b) is negative.
  function automatic logic older(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] diff;
    diff = a - b;
    return diff[31];
  endfunction

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      elig[i] = valid_q[i] & rs_rdy_q[i] & rt_rdy_q[i];
`ifdef IQ_MEM_ORDER_EN
      for (int j = 0; j < DEPTH; j++) begin
        if (valid_q[j] && entry_q[j].is_mem_access && entry_q[i].is_mem_access &&
            older(entry_q[j].count, entry_q[i].count))
          elig[i] = 1'b0;
      end
`endif
    end
  end

  always_comb begin
    found    = 1'b0;
    sel_idx  = '0;
    best_cnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (elig[i] && (!found || older(entry_q[i].count, best_cnt))) begin
        found    = 1'b1;
        sel_idx  = IDX_W'(i);
        best_cnt = entry_q[i].count;
      end
    end
  end

  always_comb begin
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid_q[i]) free_idx = IDX_W'(i);
    end
  end

  // Same-cycle wakeup and the hardwired zero register count as ready at dispatch.
  assign disp_rs_d = ~disp_entry.uses_rs | disp_rs_rdy | (disp_entry.rs_addr == 6'd0) |
                     (wb_valid & (wb_tag == disp_entry.rs_addr));
  assign disp_rt_d = ~disp_entry.uses_rt | disp_rt_rdy | (disp_entry.rt_addr == 6'd0) |
                     (wb_valid & (wb_tag == disp_entry.rt_addr));

  always_comb begin
    disp_wr       = disp_entry;
    disp_wr.count = seq_q;
  end

  assign disp_ready  = (occ_q != (IDX_W+1)'(DEPTH));
  assign issue_valid = found & ~flush;
  assign issue_idx   = sel_idx;
  assign issue_entry = found ? entry_q[sel_idx] : '0;
  assign occupancy   = occ_q;
  assign disp_fire   = disp_valid & disp_ready & ~flush;
  assign issue_fire  = issue_valid & issue_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q  <= '0;
      rs_rdy_q <= '0;
      rt_rdy_q <= '0;
      seq_q    <= SEQ_INIT;
      occ_q    <= '0;
      for (int i = 0; i < DEPTH; i++) entry_q[i] <= '0;
    end else if (flush) begin
      valid_q <= '0;
      occ_q   <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wb_valid && valid_q[i]) begin
          if (entry_q[i].rs_addr == wb_tag) rs_rdy_q[i] <= 1'b1;
          if (entry_q[i].rt_addr == wb_tag) rt_rdy_q[i] <= 1'b1;
        end
      end
      // The free slot is never the issuing slot, so these writes cannot collide.
      if (issue_fire) valid_q[sel_idx] <= 1'b0;
      if (disp_fire) begin
        valid_q[free_idx]  <= 1'b1;
        entry_q[free_idx]  <= disp_wr;
        rs_rdy_q[free_idx] <= disp_rs_d;
        rt_rdy_q[free_idx] <= disp_rt_d;
        seq_q              <= seq_q + 32'd1;
      end
      occ_q <= occ_q + (IDX_W+1)'(disp_fire) - (IDX_W+1)'(issue_fire);
    end
  end

endmodule

// File: tb/tb_iq_issue_scheduler.sv
// tb/tb_iq_issue_scheduler.sv - directed self-checking bench for iq_issue_scheduler
module tb_iq_issue_scheduler;
  import mips_core_pkg::*;

  logic               clk, rst, flush, disp_valid, disp_rs_rdy, disp_rt_rdy;
  logic               wb_valid, issue_ready;
  logic [5:0]         wb_tag;
  Instr_Queue_Entry_t disp_entry;
  logic               disp_ready, issue_valid, w_disp_ready, w_issue_valid;
  Instr_Queue_Entry_t issue_entry, w_issue_entry;
  logic [2:0]         issue_idx, w_issue_idx;
  logic [3:0]         occupancy, w_occupancy;

  int passed = 0;
  int total  = 0;

  iq_issue_scheduler #(.DEPTH(8)) u_dut (
    .clk(clk), .rst(rst), .flush(flush), .disp_valid(disp_valid), .disp_ready(disp_ready),
    .disp_entry(disp_entry), .disp_rs_rdy(disp_rs_rdy), .disp_rt_rdy(disp_rt_rdy),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_entry(issue_entry), .issue_idx(issue_idx), .occupancy(occupancy)
  );

  iq_issue_scheduler #(.DEPTH(8), .SEQ_INIT(32'hFFFF_FFFE)) u_wrap (
    .clk(clk), .rst(rst), .flush(flush), .disp_valid(disp_valid), .disp_ready(w_disp_ready),
    .disp_entry(disp_entry), .disp_rs_rdy(disp_rs_rdy), .disp_rt_rdy(disp_rt_rdy),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .issue_valid(w_issue_valid), .issue_ready(issue_ready),
    .issue_entry(w_issue_entry), .issue_idx(w_issue_idx), .occupancy(w_occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic Instr_Queue_Entry_t mk(input logic [5:0] rs, input logic urs,
                                            input logic [5:0] rt, input logic urt,
                                            input logic mem);
    Instr_Queue_Entry_t e;
    e = '0;
    e.pc = 32'h0040_0000;
    e.op = 6'h20;
    e.rs_addr = rs;
    e.uses_rs = urs;
    e.rt_addr = rt;
    e.uses_rt = urt;
    e.is_mem_access = mem;
    e.count = 32'hDEAD_BEEF;
    return e;
  endfunction

  task automatic disp(input Instr_Queue_Entry_t e, input logic rsr, input logic rtr);
    disp_valid  = 1'b1;
    disp_entry  = e;
    disp_rs_rdy = rsr;
    disp_rt_rdy = rtr;
    tick();
    disp_valid  = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    flush = 1'b0; disp_valid = 1'b0; disp_rs_rdy = 1'b0; disp_rt_rdy = 1'b0;
    wb_valid = 1'b0; wb_tag = '0; issue_ready = 1'b0; disp_entry = '0;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    // Reset state
    do_reset();
    chk("rst_occ", 32'(occupancy), 0);
    chk("rst_disp_ready", 32'(disp_ready), 1);
    chk("rst_issue_valid", 32'(issue_valid), 0);
    chk("rst_issue_idx", 32'(issue_idx), 0);
    chk("rst_issue_entry_zero", 32'(issue_entry == '0), 1);

    // Single ADD, both sources ready: no bypass, issues the next cycle
    disp_valid = 1'b1; disp_entry = mk(6'd1, 1'b1, 6'd2, 1'b1, 1'b0);
    disp_rs_rdy = 1'b1; disp_rt_rdy = 1'b1;
    #1;
    chk("t1_no_bypass", 32'(issue_valid), 0);
    tick();
    disp_valid = 1'b0;
    chk("t1_issue_valid", 32'(issue_valid), 1);
    chk("t1_count", issue_entry.count, 0);
    chk("t1_idx", 32'(issue_idx), 0);
    chk("t1_op", 32'(issue_entry.op), 32'h20);
    chk("t1_occ", 32'(occupancy), 1);
    issue_ready = 1'b1;
    tick();
    issue_ready = 1'b0;
    chk("t1_occ_after", 32'(occupancy), 0);
    chk("t1_valid_after", 32'(issue_valid), 0);

    // Fill with entries waiting on tag 5, wake them all, drain in age order
    do_reset();
    for (int k = 0; k < 8; k++) disp(mk(6'd5, 1'b1, 6'd0, 1'b0, 1'b0), 1'b0, 1'b0);
    chk("t2_full_ready", 32'(disp_ready), 0);
    chk("t2_full_issue", 32'(issue_valid), 0);
    chk("t2_full_occ", 32'(occupancy), 8);
    disp(mk(6'd0, 1'b0, 6'd0, 1'b0, 1'b0), 1'b1, 1'b1);
    chk("t2_full_drop_occ", 32'(occupancy), 8);
    wb_valid = 1'b1; wb_tag = 6'd5;
    tick();
    wb_valid = 1'b0;
    chk("t2_woke", 32'(issue_valid), 1);
    issue_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("t2_count%0d", k), issue_entry.count, 32'(k));
      chk($sformatf("t2_idx%0d", k), 32'(issue_idx), 32'(k));
      tick();
    end
    issue_ready = 1'b0;
    chk("t2_drained_occ", 32'(occupancy), 0);
    chk("t2_drained_valid", 32'(issue_valid), 0);

    // Same-cycle wakeup, selective wakeup, and re-select of an older entry
    do_reset();
    disp(mk(6'd9, 1'b1, 6'd0, 1'b0, 1'b0), 1'b0, 1'b0);
    chk("t3_wait", 32'(issue_valid), 0);
    wb_valid = 1'b1; wb_tag = 6'd7;
    disp(mk(6'd7, 1'b1, 6'd0, 1'b0, 1'b0), 1'b0, 1'b0);
    wb_valid = 1'b0;
    chk("t3_same_cycle_valid", 32'(issue_valid), 1);
    chk("t3_same_cycle_idx", 32'(issue_idx), 1);
    chk("t3_same_cycle_count", issue_entry.count, 1);
    wb_valid = 1'b1; wb_tag = 6'd9;
    tick();
    wb_valid = 1'b0;
    chk("t3_reselect_idx", 32'(issue_idx), 0);
    chk("t3_reselect_count", issue_entry.count, 0);
    do_reset();
    disp(mk(6'd0, 1'b1, 6'd0, 1'b1, 1'b0), 1'b0, 1'b0);
    chk("t3_zero_tag_ready", 32'(issue_valid), 1);

    // Sequence wrap on the second instance: A=FFFFFFFF older than B=0
    do_reset();
    disp(mk(6'd10, 1'b1, 6'd0, 1'b0, 1'b0), 1'b0, 1'b0);
    disp(mk(6'd0, 1'b0, 6'd0, 1'b0, 1'b0), 1'b1, 1'b1);
    disp(mk(6'd0, 1'b0, 6'd0, 1'b0, 1'b0), 1'b1, 1'b1);
    chk("t4_valid", 32'(w_issue_valid), 1);
    chk("t4_a_count", w_issue_entry.count, 32'hFFFF_FFFF);
    chk("t4_a_idx", 32'(w_issue_idx), 1);
    issue_ready = 1'b1;
    tick();
    issue_ready = 1'b0;
    chk("t4_b_count", w_issue_entry.count, 32'h0);
    chk("t4_b_idx", 32'(w_issue_idx), 2);
    chk("t4_occ", 32'(w_occupancy), 2);

    // Flush drops the concurrent dispatch and issue; seq keeps counting
    do_reset();
    disp(mk(6'd0, 1'b0, 6'd0, 1'b0, 1'b0), 1'b1, 1'b1);
    disp(mk(6'd0, 1'b0, 6'd0, 1'b0, 1'b0), 1'b1, 1'b1);
    flush = 1'b1; disp_valid = 1'b1; issue_ready = 1'b1;
    #1;
    chk("t5_forced_low", 32'(issue_valid), 0);
    tick();
    flush = 1'b0; disp_valid = 1'b0; issue_ready = 1'b0;
    chk("t5_occ", 32'(occupancy), 0);
    chk("t5_valid", 32'(issue_valid), 0);
    chk("t5_disp_ready", 32'(disp_ready), 1);
    disp(mk(6'd0, 1'b0, 6'd0, 1'b0, 1'b0), 1'b1, 1'b1);
    chk("t5_post_idx", 32'(issue_idx), 0);
    chk("t5_post_count", issue_entry.count, 2);
    chk("t5_post_occ", 32'(occupancy), 1);

    // Older load waiting, younger store ready
    do_reset();
    disp(mk(6'd11, 1'b1, 6'd0, 1'b0, 1'b1), 1'b0, 1'b0);
    disp(mk(6'd0, 1'b0, 6'd0, 1'b0, 1'b1), 1'b1, 1'b1);
`ifdef IQ_MEM_ORDER_EN
    chk("t6_store_held", 32'(issue_valid), 0);
    wb_valid = 1'b1; wb_tag = 6'd11;
    tick();
    wb_valid = 1'b0;
    chk("t6_load_first_idx", 32'(issue_idx), 0);
`else
    chk("t6_store_valid", 32'(issue_valid), 1);
    chk("t6_store_idx", 32'(issue_idx), 1);
    chk("t6_store_count", issue_entry.count, 1);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
